// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB3 requester: valid/ready command port to SETUP/ACCESS transfers with PREADY watchdog
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic [CW-1:0]         r_wdog, w_wdog_nxt;
  logic                  w_wdog_hit;

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle that still sees PREADY low
  assign w_wdog_hit = (TIMEOUT_CYCLES > 0) &&
                      ((32'(r_wdog) + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_ready_nxt   = r_cmd_ready;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_wdog_nxt        = r_wdog;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt     = ST_SETUP;
          w_cmd_ready_nxt = 1'b0;
          w_pwrite_nxt    = cmd_write;
          w_paddr_nxt     = cmd_addr;
          w_pwdata_nxt    = cmd_wdata;
          w_psel_nxt      = 1'b1;
          w_penable_nxt   = 1'b0;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_penable_nxt = 1'b1;
        w_wdog_nxt    = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_state_nxt       = ST_RESP;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
        end else if (w_wdog_hit) begin
          w_state_nxt       = ST_RESP;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_rdata_nxt   = '0;
        end else if (r_wdog != {CW{1'b1}}) begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_wdog        <= w_wdog_nxt;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - table-driven bench for apb_master_bridge with a small APB RAM completer
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  int          wait_states = 0;
  logic        slverr_cfg  = 1'b0;
  logic        stuck       = 1'b0;
  int          acc_cnt     = 0;
  logic [31:0] mem [256];

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Completer: inserts wait_states low-PREADY ACCESS cycles, or never answers when stuck
  assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt == wait_states);
  assign PSLVERR = PREADY && slverr_cfg;
  assign PRDATA  = mem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PREADY && PWRITE && !slverr_cfg) mem[PADDR] <= PWDATA;
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic        stk;
    int          exp_psel;
    int          exp_pen;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int   psel_n = 0;
    int   pen_n  = 0;
    int   cyc    = 0;
    logic bus_ok = 1'b1;
    string pfx;
    pfx = $sformatf("v%0d", idx);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    wait_states = v.waits; slverr_cfg = v.slverr; stuck = v.stk;
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    while (!rsp_valid && cyc < 64) begin
      if (PSEL) psel_n++;
      if (PENABLE) pen_n++;
      if (PSEL && (PADDR !== v.addr || PWRITE !== v.wr)) bus_ok = 1'b0;
      if (PSEL && v.wr && PWDATA !== v.wdata) bus_ok = 1'b0;
      @(negedge PCLK);
      cyc++;
    end
    chk({pfx, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    chk({pfx, "_psel_cycles"}, 32'(psel_n), 32'(v.exp_psel));
    chk({pfx, "_penable_cycles"}, 32'(pen_n), 32'(v.exp_pen));
    chk({pfx, "_bus_stable"}, 32'(bus_ok), 32'd1);
    chk({pfx, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({pfx, "_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({pfx, "_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
    chk({pfx, "_psel_in_resp"}, 32'({PSEL, PENABLE}), 32'd0);
    @(negedge PCLK);
    chk({pfx, "_rsp_held"}, 32'({rsp_valid, rsp_err, rsp_timeout}), 32'({1'b1, v.exp_err, v.exp_to}));
    chk({pfx, "_rdata_held"}, rsp_rdata, v.exp_rdata);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk({pfx, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {24'hA5A5A5, 8'(i)};
    //          wr    addr   wdata         wt slv  stk psel pen rdata         err   to
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0,  1'b0, 1'b0, 2,  1,  32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h10, 32'h0,        0,  1'b0, 1'b0, 2,  1,  32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h20, 32'h0,        3,  1'b0, 1'b0, 5,  4,  32'hA5A5A520, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h04, 32'h0BADF00D, 0,  1'b1, 1'b0, 2,  1,  32'h0,        1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h30, 32'h0,        0,  1'b0, 1'b1, 17, 16, 32'h0,        1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h10, 32'h0,        15, 1'b0, 1'b0, 17, 16, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h44, 32'h12345678, 2,  1'b0, 1'b0, 4,  3,  32'h0,        1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h44, 32'h0,        1,  1'b0, 1'b0, 3,  2,  32'h12345678, 1'b0, 1'b0};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("reset_bus", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
    chk("reset_paddr", 32'(PADDR), 32'd0);
    chk("reset_pwdata", PWDATA, 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    PRESET = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Reset while the bridge is waiting in ACCESS: transfer is dropped silently
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; stuck = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("mid_access_penable", 32'({PSEL, PENABLE}), 32'd3);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0; stuck = 1'b0;
    chk("mid_reset_bus", 32'({PSEL, PENABLE}), 32'd0);
    chk("mid_reset_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    chk("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
    run_txn(vecs[1], 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
